bit_serial_adder: RTL and testbench

Sequential stage that drives the team's 1-bit half-adder cell. It accepts two WIDTH-bit operands and feeds them LSB-first, one bit pair per clock, through a full adder built from two half-adder cells plus a carry flip-flop. It then presents the WIDTH-bit sum and carry-out with a one-cycle completion pulse. It is the next step after the combinational half-adder demo: the same arithmetic cell, reused serially under a small FSM.

---
 rtl/bit_serial_pkg.sv | 19 +
 rtl/half_adder_cell.sv | 16 +
 rtl/bit_serial_adder.sv | 105 ++++++++++
 tb/tb_bit_serial_adder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
`default_nettype none

package bit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width for a given operand width: $clog2(width), at least 1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/half_adder_cell.sv
// 1-bit half-adder cell; two of these form the serial full adder.
`default_nettype none

module half_adder_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

`default_nettype wire

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one bit pair per clock through two half-adder
// cells and a carry flip-flop, with registered sum/cout and a done pulse.
`default_nettype none

module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic p, g1, s_bit, g2;
  logic next_carry;
  logic [WIDTH-1:0] next_res;

  half_adder_cell u_ha1 (
    .x (a_sr[0]),
    .y (b_sr[0]),
    .s (p),
    .c (g1)
  );

  half_adder_cell u_ha2 (
    .x (p),
    .y (carry),
    .s (s_bit),
    .c (g2)
  );

  assign next_carry = g1 | g2;
  assign next_res   = {s_bit, res_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          carry  <= next_carry;
          res_sr <= next_res;
          cnt    <= cnt + 1'b1;
          // Last bit: publish the result including this cycle's sum bit.
          if (cnt == LAST) begin
            sum   <= next_res;
            cout  <= next_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder at WIDTH=8 and WIDTH=4.
`default_nettype none

module tb_bit_serial_adder;

  logic       clk;
  logic       rst;
  logic       start8, start4;
  logic [7:0] a8, b8;
  logic [3:0] a4, b4;
  logic       busy8, done8, cout8;
  logic       busy4, done4, cout4;
  logic [7:0] sum8;
  logic [3:0] sum4;

  int checks = 0;
  int errors = 0;
  int done_cnt8 = 0;
  logic [8:0] exp8[$];
  logic [4:0] exp4[$];

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  bit_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop an expected result on every done pulse.
  always @(negedge clk) begin
    if (done8) begin
      done_cnt8++;
      if (exp8.size() == 0) chk("unexpected_done8", 1, 0);
      else chk("result8", {23'd0, cout8, sum8}, {23'd0, exp8.pop_front()});
    end
    if (done4) begin
      if (exp4.size() == 0) chk("unexpected_done4", 1, 0);
      else chk("result4", {27'd0, cout4, sum4}, {27'd0, exp4.pop_front()});
    end
  end

  // Counts edges after the accept edge until done; busy must mirror !done.
  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      chk("busy8", busy8, !done8);
    end while (!done8 && n < 40);
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      chk("busy4", busy4, !done4);
    end while (!done4 && n < 40);
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [8:0] ev);
    int n;
    a8 = av; b8 = bv; start8 = 1'b1;
    exp8.push_back(ev);
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("busy8_after_accept", busy8, 1);
    wait_done8(n);
    chk("latency8", n, 8);
    @(posedge clk); #1;
    chk("done8_one_cycle", done8, 0);
  endtask

  initial begin
    int n;
    int dc;
    logic [4:0] e4;
    rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_cout8", cout8, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_sum4", sum4, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic add and overflow cases
    run8(8'h5A, 8'h3C, 9'h096);
    run8(8'hFF, 8'h01, 9'h100);
    run8(8'hFF, 8'hFF, 9'h1FE);
    chk("sum8_holds", {cout8, sum8}, 9'h1FE);

    // Start while busy is ignored
    dc = done_cnt8;
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    exp8.push_back(9'h011);
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (25) begin @(posedge clk); #1; end
    chk("busy_start_done_count", done_cnt8 - dc, 1);
    chk("busy_start_sum", {cout8, sum8}, 9'h011);

    // Reset in the 4th SHIFT cycle
    a8 = 8'h0F; b8 = 8'h0F; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", busy8, 0);
    chk("midrst_sum", sum8, 0);
    chk("midrst_cout", cout8, 0);
    dc = done_cnt8;
    repeat (20) begin @(posedge clk); #1; end
    chk("midrst_no_done", done_cnt8 - dc, 0);

    // Back-to-back with start held high
    a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
    exp8.push_back(9'h003);
    @(posedge clk); #1;
    wait_done8(n);
    chk("b2b_latency1", n, 8);
    a8 = 8'h80; b8 = 8'h80;
    exp8.push_back(9'h100);
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("b2b_busy_again", busy8, 1);
    wait_done8(n);
    chk("b2b_spacing", n + 1, 9);
    @(posedge clk); #1;

    // WIDTH=4 exhaustive sweep, back-to-back
    a4 = 4'd0; b4 = 4'd0; start4 = 1'b1;
    exp4.push_back(5'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) begin
      wait_done4(n);
      chk("sweep_spacing4", n + 1, 5);
      if (i < 255) begin
        a4 = 4'((i + 1) >> 4);
        b4 = 4'((i + 1) & 15);
        e4 = {1'b0, a4} + {1'b0, b4};
        exp4.push_back(e4);
      end else begin
        start4 = 1'b0;
      end
      @(posedge clk); #1;
    end
    repeat (4) begin @(posedge clk); #1; end

    chk("exp8_drained", exp8.size(), 0);
    chk("exp4_drained", exp4.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
